// File: rtl/pslip_pkg.sv
// Shared types and helpers for the PSLIP iteration controller.
package pslip_pkg;

  localparam int unsigned ITER_DFLT = 3;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StAccept,
    StCheck,
    StDone
  } state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int unsigned lsb_index(input logic [31:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/pslip_lsb_enc.sv
// Converts one accept row into a (valid, lowest-set-bit index) pair.
module pslip_lsb_enc
  import pslip_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_row,
  output logic          o_vld,
  output logic [IW-1:0] o_idx
);

  logic [31:0] w_vec;

  always_comb begin
    w_vec        = '0;
    w_vec[N-1:0] = i_row;
  end

  assign o_vld = |i_row;
  assign o_idx = IW'(lsb_index(w_vec));

endmodule

// File: rtl/pslip_iter_ctrl.sv
// Iteration controller for an iSLIP-style scheduler: sequences grant/accept phases and
// records matches. Optional statistics enabled by defining PSLIP_ITER_STATS_EN.
module pslip_iter_ctrl
  import pslip_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned ITER = ITER_DFLT,
  localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned CW  = $clog2(ITER + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [N-1:0][N-1:0]    i_acc_vec,
  output logic                   o_grant_en,
  output logic                   o_accept_en,
  output logic                   o_update_en,
  output logic [N-1:0]           o_in_mask,
  output logic [N-1:0]           o_out_mask,
  output logic [N-1:0]           o_match_vld,
  output logic [N-1:0][IW-1:0]   o_match_port,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [CW-1:0]          o_iter_used,
  output logic [15:0]            o_round_cnt
);

  state_e                r_state;
  logic                  r_grant_en;
  logic                  r_accept_en;
  logic                  r_update_en;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_new_match;
  logic [CW-1:0]         r_iter;
  logic [N-1:0]          r_in_mask;
  logic [N-1:0]          r_out_mask;
  logic [N-1:0][IW-1:0]  r_match_port;

  logic [N-1:0]          w_vld;
  logic [N-1:0][IW-1:0]  w_idx;
  logic [N-1:0]          w_in_new;
  logic [N-1:0]          w_out_new;
  logic [CW-1:0]         w_iter_inc;
  logic                  w_fin;

  for (genvar g = 0; g < N; g++) begin : g_enc
    pslip_lsb_enc #(
      .N  (N),
      .IW (IW)
    ) u_enc (
      .i_row (i_acc_vec[g]),
      .o_vld (w_vld[g]),
      .o_idx (w_idx[g])
    );
  end

  // Scanning inputs in ascending order lets the lowest index win a contested output.
  always_comb begin
    w_in_new  = '0;
    w_out_new = '0;
    for (int i = 0; i < N; i++) begin
      if (!r_in_mask[i] && w_vld[i] && !r_out_mask[w_idx[i]] && !w_out_new[w_idx[i]]) begin
        w_in_new[i]         = 1'b1;
        w_out_new[w_idx[i]] = 1'b1;
      end
    end
  end

  assign w_iter_inc = r_iter + CW'(1);
  assign w_fin      = !r_new_match || (w_iter_inc == CW'(ITER)) || (&r_in_mask);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_grant_en   <= 1'b0;
      r_accept_en  <= 1'b0;
      r_update_en  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_new_match  <= 1'b0;
      r_iter       <= '0;
      r_in_mask    <= '0;
      r_out_mask   <= '0;
      r_match_port <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_in_mask    <= '0;
            r_out_mask   <= '0;
            r_match_port <= '0;
            r_iter       <= '0;
            r_busy       <= 1'b1;
            r_grant_en   <= 1'b1;
            r_state      <= StGrant;
          end
        end
        StGrant: begin
          r_grant_en  <= 1'b0;
          r_accept_en <= 1'b1;
          // Arbiter pointers only move on the first iteration.
          r_update_en <= (r_iter == '0);
          r_state     <= StAccept;
        end
        StAccept: begin
          r_accept_en <= 1'b0;
          r_update_en <= 1'b0;
          r_in_mask   <= r_in_mask | w_in_new;
          r_out_mask  <= r_out_mask | w_out_new;
          r_new_match <= |w_in_new;
          for (int i = 0; i < N; i++) begin
            if (w_in_new[i]) r_match_port[i] <= w_idx[i];
          end
          r_state <= StCheck;
        end
        StCheck: begin
          r_iter <= w_iter_inc;
          if (w_fin) begin
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_grant_en <= 1'b1;
            r_state    <= StGrant;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_grant_en   = r_grant_en;
  assign o_accept_en  = r_accept_en;
  assign o_update_en  = r_update_en;
  assign o_in_mask    = r_in_mask;
  assign o_out_mask   = r_out_mask;
  assign o_match_vld  = r_in_mask;
  assign o_match_port = r_match_port;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

`ifdef PSLIP_ITER_STATS_EN
  logic [CW-1:0] r_iter_used;
  logic [15:0]   r_round_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_iter_used <= '0;
      r_round_cnt <= '0;
    end else if ((r_state == StCheck) && w_fin) begin
      r_iter_used <= w_iter_inc;
      if (r_round_cnt != 16'hFFFF) r_round_cnt <= r_round_cnt + 16'd1;
    end
  end

  assign o_iter_used = r_iter_used;
  assign o_round_cnt = r_round_cnt;
`else
  assign o_iter_used = '0;
  assign o_round_cnt = '0;
`endif

endmodule

// File: tb/tb_pslip_iter_ctrl.sv
// Self-checking bench for pslip_iter_ctrl (N=4, ITER=3); honours PSLIP_ITER_STATS_EN.
module tb_pslip_iter_ctrl;

  localparam int N    = 4;
  localparam int ITER = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [3:0][3:0] acc = '0;

  logic            grant_en, accept_en, update_en, busy, done;
  logic [3:0]      in_mask, out_mask, match_vld;
  logic [3:0][1:0] match_port;
  logic [1:0]      iter_used;
  logic [15:0]     round_cnt;

  pslip_iter_ctrl #(
    .N    (N),
    .ITER (ITER)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_acc_vec    (acc),
    .o_grant_en   (grant_en),
    .o_accept_en  (accept_en),
    .o_update_en  (update_en),
    .o_in_mask    (in_mask),
    .o_out_mask   (out_mask),
    .o_match_vld  (match_vld),
    .o_match_port (match_port),
    .o_busy       (busy),
    .o_done       (done),
    .o_iter_used  (iter_used),
    .o_round_cnt  (round_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // Model: a round is a sequence of 3-cycle iterations (grant, accept, check) counted
  // from the start edge, followed by one done cycle.
  bit         m_active, m_donecyc, m_new;
  int         m_k, m_iter, m_used, m_rounds;
  logic [3:0] m_in, m_out;
  int         m_port[4];

  always @(posedge clk) begin
    int j;
    int exp_port;
    ecnt++;
    if (!rst_n) begin
      m_active  = 0;
      m_donecyc = 0;
      m_new     = 0;
      m_k       = 0;
      m_iter    = 0;
      m_used    = 0;
      m_rounds  = 0;
      m_in      = '0;
      m_out     = '0;
      for (int i = 0; i < 4; i++) m_port[i] = 0;
    end else if (m_donecyc) begin
      m_donecyc = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1;
        m_k      = 0;
        m_iter   = 0;
        m_in     = '0;
        m_out    = '0;
        for (int i = 0; i < 4; i++) m_port[i] = 0;
      end
    end else begin
      if (m_k % 3 == 1) begin
        m_new = 0;
        for (int i = 0; i < 4; i++) begin
          if (!m_in[i] && acc[i] != 4'b0) begin
            j = 0;
            while (!acc[i][j]) j++;
            if (!m_out[j]) begin
              m_in[i]   = 1'b1;
              m_out[j]  = 1'b1;
              m_port[i] = j;
              m_new     = 1;
            end
          end
        end
      end else if (m_k % 3 == 2) begin
        m_iter++;
        if (!m_new || m_iter == ITER || m_in == 4'hF) begin
          m_active  = 0;
          m_donecyc = 1;
          m_used    = m_iter;
          if (m_rounds < 65535) m_rounds++;
        end
      end
      m_k++;
    end
    #1;
    exp_port = m_port[0] + 4 * m_port[1] + 16 * m_port[2] + 64 * m_port[3];
    chk("grant_en", int'(grant_en), int'(m_active && (m_k % 3 == 0)));
    chk("accept_en", int'(accept_en), int'(m_active && (m_k % 3 == 1)));
    chk("update_en", int'(update_en), int'(m_active && (m_k % 3 == 1) && (m_k < 3)));
    chk("busy", int'(busy), int'(m_active || m_donecyc));
    chk("done", int'(done), int'(m_donecyc));
    chk("in_mask", int'(in_mask), int'(m_in));
    chk("out_mask", int'(out_mask), int'(m_out));
    chk("match_vld", int'(match_vld), int'(m_in));
    chk("match_port", int'(match_port), exp_port);
`ifdef PSLIP_ITER_STATS_EN
    chk("iter_used", int'(iter_used), m_used);
    chk("round_cnt", int'(round_cnt), m_rounds);
`else
    chk("iter_used", int'(iter_used), 0);
    chk("round_cnt", int'(round_cnt), 0);
`endif
  end

  task automatic start_pulse(output int t0);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 t0 = ecnt;
    @(negedge clk) start = 1'b0;
  endtask

  // Runs from the negedge after the start edge until done, optionally swapping acc
  // or pulsing start on given edges; reports done latency and update_en cycle count.
  task automatic wait_done(input string nm, input int t0, input int exp_dt, input int chg_at,
                           input logic [3:0][3:0] chg_acc, input int pulse_at,
                           output int ups);
    bit seen;
    int done_at;
    seen = 0;
    ups  = 0;
    done_at = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (ecnt == t0 + chg_at) acc = chg_acc;
      start = (ecnt == t0 + pulse_at);
      if (update_en) ups++;
      if (done) begin
        seen    = 1;
        done_at = ecnt + 1;
      end else begin
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!seen) chk({nm, " timeout"}, 0, 1);
    else chk({nm, " done_at"}, done_at - t0, exp_dt);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t0, ups;
    int rc0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Diagonal accept: everything matches in iteration 0.
    acc = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    start_pulse(t0);
    wait_done("diag", t0, 4, -10, acc, -10, ups);
    chk("diag ups", ups, 1);
    chk("diag in_mask", int'(in_mask), 15);
    chk("diag port", int'(match_port), 228);
`ifdef PSLIP_ITER_STATS_EN
    chk("diag iter_used", int'(iter_used), 1);
`endif

    // Contention then a second-iteration match; third iteration finds nothing.
    acc = {4'b0000, 4'b0000, 4'b0001, 4'b0001};
    start_pulse(t0);
    wait_done("contend", t0, 10, 2, {4'b0000, 4'b0000, 4'b0010, 4'b0001}, -10, ups);
    chk("contend ups", ups, 1);
    chk("contend vld", int'(match_vld), 3);
    chk("contend out_mask", int'(out_mask), 3);
    chk("contend port", int'(match_port), 4);
`ifdef PSLIP_ITER_STATS_EN
    chk("contend iter_used", int'(iter_used), 3);
`endif

    // No requests at all.
    acc = '0;
    start_pulse(t0);
    wait_done("empty", t0, 4, -10, acc, -10, ups);
    chk("empty in_mask", int'(in_mask), 0);
    chk("empty out_mask", int'(out_mask), 0);

    // Non-one-hot row resolves to its lowest set bit.
    acc = {4'b0000, 4'b0000, 4'b0000, 4'b0110};
    start_pulse(t0);
    wait_done("lsb", t0, 7, -10, acc, -10, ups);
    chk("lsb port", int'(match_port), 1);
    chk("lsb vld", int'(match_vld), 1);

    // Reset during the accept phase of iteration 1.
    acc = {4'b0000, 4'b0000, 4'b0001, 4'b0001};
    start_pulse(t0);
    while (ecnt < t0 + 4) begin
      if (ecnt == t0 + 2) acc = {4'b0000, 4'b0000, 4'b0010, 4'b0001};
      @(negedge clk);
    end
    chk("pre-reset accept_en", int'(accept_en), 1);
    rst_n = 1'b0;
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst vld", int'(match_vld), 0);
    chk("rst accept_en", int'(accept_en), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst no done", int'(done), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    acc = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    start_pulse(t0);
    wait_done("post-rst", t0, 4, -10, acc, -10, ups);
    chk("post-rst in_mask", int'(in_mask), 15);

    // Start pulsed while busy must be ignored.
    rc0 = int'(round_cnt);
    start_pulse(t0);
    wait_done("restart", t0, 4, -10, acc, 1, ups);
    chk("restart busy after", int'(busy), 0);
`ifdef PSLIP_ITER_STATS_EN
    chk("restart round_cnt", int'(round_cnt) - rc0, 1);
`else
    chk("restart round_cnt", int'(round_cnt) - rc0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
